// File: rtl/mux_pkg.sv
// Shared definitions for the 16:1 word multiplexer slice.
package mux_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/mux_16_mux4_w.sv
// Combinational 4:1 word multiplexer, the building block of the mux_16 tree.
module mux4_w #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  // A full case on a 2-bit select means only the chosen input ever reaches y_o.
  always_comb begin
    y_o = '0;
    case (sel_i)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/mux_16.sv
// 16:1 word multiplexer with a single registered output stage and async reset.
module mux_16
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s3,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i8,
  input  logic [WIDTH-1:0] i9,
  input  logic [WIDTH-1:0] i10,
  input  logic [WIDTH-1:0] i11,
  input  logic [WIDTH-1:0] i12,
  input  logic [WIDTH-1:0] i13,
  input  logic [WIDTH-1:0] i14,
  input  logic [WIDTH-1:0] i15,
  output logic [WIDTH-1:0] op
);

  logic [1:0]       sel_lo;
  logic [1:0]       sel_hi;
  logic [WIDTH-1:0] grp0;
  logic [WIDTH-1:0] grp1;
  logic [WIDTH-1:0] grp2;
  logic [WIDTH-1:0] grp3;
  logic [WIDTH-1:0] op_d;
  logic [WIDTH-1:0] op_q;

  assign sel_lo = {s1, s0};
  assign sel_hi = {s3, s2};

  // First level picks within each group of four, second level picks the group.
  mux4_w #(.WIDTH(WIDTH)) u_grp0 (
    .sel_i(sel_lo), .d0_i(i0),  .d1_i(i1),  .d2_i(i2),  .d3_i(i3),  .y_o(grp0)
  );
  mux4_w #(.WIDTH(WIDTH)) u_grp1 (
    .sel_i(sel_lo), .d0_i(i4),  .d1_i(i5),  .d2_i(i6),  .d3_i(i7),  .y_o(grp1)
  );
  mux4_w #(.WIDTH(WIDTH)) u_grp2 (
    .sel_i(sel_lo), .d0_i(i8),  .d1_i(i9),  .d2_i(i10), .d3_i(i11), .y_o(grp2)
  );
  mux4_w #(.WIDTH(WIDTH)) u_grp3 (
    .sel_i(sel_lo), .d0_i(i12), .d1_i(i13), .d2_i(i14), .d3_i(i15), .y_o(grp3)
  );

  mux4_w #(.WIDTH(WIDTH)) u_top (
    .sel_i(sel_hi), .d0_i(grp0), .d1_i(grp1), .d2_i(grp2), .d3_i(grp3), .y_o(op_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
    end else begin
      op_q <= op_d;
    end
  end

  assign op = op_q;

endmodule

// File: tb/tb_mux_16.sv
// Directed self-checking bench for mux_16: vector table plus multi-cycle corner sequences.
module tb_mux_16;
  import mux_pkg::*;

  typedef struct {
    logic [3:0] sel;
    word_t      base;
    word_t      exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  word_t       din [16];
  word_t       op;
  int          checks;
  int          errors;
  vec_t        vecs [6];

  mux_16 #(.WIDTH(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s3(sel[3]), .s2(sel[2]), .s1(sel[1]), .s0(sel[0]),
    .i0(din[0]),   .i1(din[1]),   .i2(din[2]),   .i3(din[3]),
    .i4(din[4]),   .i5(din[5]),   .i6(din[6]),   .i7(din[7]),
    .i8(din[8]),   .i9(din[9]),   .i10(din[10]), .i11(din[11]),
    .i12(din[12]), .i13(din[13]), .i14(din[14]), .i15(din[15]),
    .op(op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_ramp(input word_t base);
    for (int n = 0; n < 16; n++) din[n] = base + word_t'(n);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    checks = 0;
    errors = 0;

    // i_n = base + n, so the expected word is base + sel (16-bit wrap)
    vecs[0] = '{sel: 4'd5,  base: 16'h0000, exp: 16'h0005};
    vecs[1] = '{sel: 4'd15, base: 16'h1000, exp: 16'h100F};
    vecs[2] = '{sel: 4'd0,  base: 16'hFFF0, exp: 16'hFFF0};
    vecs[3] = '{sel: 4'd7,  base: 16'hFFF9, exp: 16'h0000};
    vecs[4] = '{sel: 4'd12, base: 16'hABC0, exp: 16'hABCC};
    vecs[5] = '{sel: 4'd10, base: 16'h8000, exp: 16'h800A};

    rst = 1'b1;
    sel = 4'd8;
    set_ramp(16'h0000);
    #1;
    check("reset_state", op, 16'h0000);
    after_edge();
    check("reset_hold_edge", op, 16'h0000);

    // Release, load 8, then async reset between edges with sel = 5
    @(negedge clk);
    rst = 1'b0;
    after_edge();
    check("post_release_load", op, 16'h0008);
    @(negedge clk);
    sel = 4'd5;
    rst = 1'b1;
    #1;
    check("reset_immediate", op, 16'h0000);
    after_edge();
    check("reset_hold_across_edge", op, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_no_edge_yet", op, 16'h0000);
    after_edge();
    check("release_first_edge", op, 16'h0005);

    // Sweep every code: before the edge op still shows the previous select
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      sel = 4'(k);
      #1;
      check("sweep_pre_edge", op, (k == 0) ? 16'h0005 : word_t'(k - 1));
      after_edge();
      check("sweep_post_edge", op, word_t'(k));
    end

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      sel = vecs[v].sel;
      set_ramp(vecs[v].base);
      after_edge();
      check("table_vec", op, vecs[v].exp);
    end

    // Data pattern on sel = 10
    @(negedge clk);
    for (int n = 0; n < 16; n++) din[n] = 16'hFFFF;
    din[10] = 16'hA5A5;
    sel = 4'd10;
    after_edge();
    check("pattern_a5a5", op, 16'hA5A5);
    @(negedge clk);
    din[10] = 16'h5A5A;
    #1;
    check("pattern_not_before_edge", op, 16'hA5A5);
    after_edge();
    check("pattern_5a5a", op, 16'h5A5A);

    // Unselected inputs toggle, op stays on i3
    @(negedge clk);
    sel = 4'd3;
    din[3] = 16'h1234;
    after_edge();
    check("isolate_initial", op, 16'h1234);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int n = 0; n < 16; n++)
        if (n != 3) din[n] = (c % 2 == 0) ? 16'h0000 : ~word_t'($urandom());
      after_edge();
      check("isolate_toggle", op, 16'h1234);
    end

    // Short reset pulse mid-sweep at sel = 9
    @(negedge clk);
    set_ramp(16'h0000);
    sel = 4'd9;
    after_edge();
    check("midrun_before_pulse", op, 16'h0009);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_pulse_drop", op, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    check("midrun_after_release", op, 16'h0000);
    after_edge();
    check("midrun_resume", op, 16'h0009);

    // Simultaneous select and data change
    @(negedge clk);
    sel = 4'd2;
    din[2] = 16'h2222;
    din[14] = 16'h0000;
    after_edge();
    check("simul_before", op, 16'h2222);
    @(negedge clk);
    sel = 4'd14;
    din[14] = 16'hBEEF;
    #1;
    check("simul_pre_edge", op, 16'h2222);
    after_edge();
    check("simul_after", op, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
